// File: rtl/time_formatter.sv
// Serialises a latched binary time into the ASCII frame "T:HH:MM:SS\n", one byte
// per valid/ready handshake. Fields are snapshotted when an idle start is accepted.
module time_formatter #(
  parameter logic [7:0] PREFIX = 8'h54,
  parameter logic [7:0] SEP    = 8'h3A,
  parameter logic [7:0] TERM   = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       tx_ready,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic [4:0] hour_reg, hour_next;
  logic [5:0] min_reg, min_next;
  logic [5:0] sec_reg, sec_next;
  logic       done_reg, done_next;

  // Tens digit by compare chain; inputs never exceed 63, so 6 is the ceiling.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [3:0] t;
    if      (v >= 6'd60) t = 4'd6;
    else if (v >= 6'd50) t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  logic [2:0][5:0] field_val;
  logic [2:0][7:0] tens_chr;
  logic [2:0][7:0] units_chr;

  assign field_val[0] = {1'b0, hour_reg};
  assign field_val[1] = min_reg;
  assign field_val[2] = sec_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      logic [3:0] tens_d;
      logic [5:0] tens_x10;
      logic [5:0] units_full;
      assign tens_d        = tens_of(field_val[gi]);
      assign tens_x10      = {2'b00, tens_d} * 6'd10;
      assign units_full    = field_val[gi] - tens_x10;
      assign tens_chr[gi]  = ascii_of(tens_d);
      assign units_chr[gi] = ascii_of(units_full[3:0]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= 4'd0;
      hour_reg  <= 5'd0;
      min_reg   <= 6'd0;
      sec_reg   <= 6'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      hour_reg  <= hour_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hour_next  = hour_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          idx_next   = 4'd0;
          hour_next  = hour;
          min_next   = min;
          sec_next   = sec;
        end
      end
      SEND: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        if (tx_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = 4'd0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [7:0] frame_byte;

  always_comb begin
    frame_byte = 8'h00;
    case (idx_reg)
      4'd0:             frame_byte = PREFIX;
      4'd1, 4'd4, 4'd7: frame_byte = SEP;
      4'd2:             frame_byte = tens_chr[0];
      4'd3:             frame_byte = units_chr[0];
      4'd5:             frame_byte = tens_chr[1];
      4'd6:             frame_byte = units_chr[1];
      4'd8:             frame_byte = tens_chr[2];
      4'd9:             frame_byte = units_chr[2];
      4'd10:            frame_byte = TERM;
      default:          frame_byte = 8'h00;
    endcase
  end

  // Outputs decode straight from registered state, so the first byte appears
  // right after the start edge and resets clear them without waiting for a clock.
  assign data_valid = (state_reg == SEND);
  assign busy       = (state_reg == SEND);
  assign data       = (state_reg == SEND) ? frame_byte : 8'h00;
  assign done       = done_reg;

endmodule

// File: doc/time_formatter.md
# time_formatter

- Transmit-side counterpart of `time_parser`: serializes a binary time value into the ASCII frame `T:HH:MM:SS\n`, one byte at a time.
- Drives a byte-wide valid/ready stream, normally into the UART transmitter, so that a remote `time_parser` can re-sync its clock.
- Time fields are captured on a start request, so the frame always reflects one consistent snapshot.

## Interface

Parameters:
- `PREFIX` — default 8'h54 (`T`); first byte of every frame.
- `SEP` — default 8'h3A (`:`); field separator.
- `TERM` — default 8'h0A (`\n`); frame terminator.

Ports:
- `clk` — in, 1; system clock, all logic on rising edge.
- `rst` — in, 1; asynchronous, active-low reset.
- `start` — in, 1; request one frame; honoured only when `busy`=0.
- `hour` — in, 5; binary hours, sampled on accepted `start`.
- `min` — in, 6; binary minutes, sampled on accepted `start`.
- `sec` — in, 6; binary seconds, sampled on accepted `start`.
- `tx_ready` — in, 1; downstream can take a byte this cycle.
- `data` — out, 8; current ASCII byte.
- `data_valid` — out, 1; `data` is valid and held until accepted.
- `busy` — out, 1; a frame is in progress.
- `done` — out, 1; one-cycle pulse after the terminator is accepted.

## Operation

State machine:
- IDLE → SEND when `start`=1. This edge latches `hour`/`min`/`sec` and sets byte index to 0.
- SEND → SEND while bytes remain; the index advances on each accepted byte.
- SEND → IDLE when byte 10 is accepted; `done` pulses at that edge.

Frame bytes, indices 0..10:
- 0 `PREFIX`, 1 `SEP`, 2 hour tens, 3 hour units, 4 `SEP`.
- 5 min tens, 6 min units, 7 `SEP`, 8 sec tens, 9 sec units, 10 `TERM`.

Digit conversion:
- tens = v/10, units = v%10, using latched values. Combinational compare/subtract is sufficient.
- ASCII digit = 8'h30 + digit.
- No range check. Hour 24..31 emits tens `2`/`3`. Min/sec 60..63 emit tens `6`. All results remain valid ASCII digits.

Handshake:
- A byte is accepted at a rising edge where `data_valid`=1 and `tx_ready`=1.
- `data` and `data_valid` stay stable until acceptance. `tx_ready` may toggle arbitrarily; a low `tx_ready` simply stalls.

Other behaviour:
- `start` while `busy`=1 is ignored; no queuing, and latched fields are unchanged.
- `hour`/`min`/`sec` changing mid-frame has no effect.
- Reset asserted mid-frame: the frame is abandoned immediately, with no partial resume after release.

## Timing

Reset values (`rst`=0):
- State IDLE, index 0.
- `data`=8'h00, `data_valid`=0, `busy`=0, `done`=0, latched fields 0.

Start latency:
- `start` sampled high at edge N (IDLE) → from after edge N, `busy`=1, `data_valid`=1, `data`=`PREFIX`.
- No cycle is lost between request and first byte.

Throughput:
- Byte accepted at edge K → the next byte is on `data` after edge K, with `data_valid` still 1.
- With `tx_ready` held 1, the full frame takes exactly 11 cycles.

End of frame:
- Terminator accepted at edge E → after E: `data_valid`=0, `busy`=0, `done`=1 for one cycle.
- `data` returns to 8'h00 in IDLE.

Back-to-back:
- `start` high at edge E+1 (first IDLE edge) is accepted.
- Minimum frame-to-frame period is 12 cycles.

Simultaneous events:
- `start` at the same edge as terminator acceptance is ignored (`busy` still 1 at that edge).

## Test plan

- **Basic frame:** reset, then `hour`=12, `min`=34, `sec`=56, one-cycle `start`, `tx_ready`=1 → bytes 54 3A 31 32 3A 33 34 3A 35 36 0A on 11 consecutive cycles; `done` pulses once; `busy` low after.
- **Backpressure:** same frame with `tx_ready` alternating 1/0, plus a 5-cycle low while byte 5 is pending → identical byte sequence; `data` stable during every stall; no byte dropped or duplicated.
- **Snapshot and ignored start:** start with 09:05:07, then mid-frame change inputs to 23:59:59 and pulse `start` → frame reads `T:09:05:07\n`; exactly one `done`.
- **Boundaries:** 00:00:00 → `T:00:00:00\n`; 23:59:59 → `T:23:59:59\n`; out-of-range 31:63:63 → `T:31:63:63\n`.
- **Reset mid-frame:** drop `rst` after byte 4 is accepted → `data_valid`, `busy`, `done` go 0 immediately. After release, a new `start` with 01:02:03 produces a full `T:01:02:03\n`.
- **Loopback:** feed `data`/`data_valid` into `time_parser` with `tx_ready`=1 → parser reports `hour`=12, `min`=34, `sec`=56 and `synced`=1.
